mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 205 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// RV32I MEM stage: passes ALU results through, runs loads/stores as byte-serial
// transactions on an 8-bit memory port. Optional `MEM_MISALIGN_CHECK_EN drops misaligned H/W accesses.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rd_in,
  input  logic [31:0]       rd_val_in,
  input  logic [4:0]        rd_addr_in,
  input  logic              load_in,
  input  logic              store_in,
  input  logic [2:0]        funct3_in,
  input  logic [31:0]       mem_addr_in,
  input  logic [31:0]       mem_val_in,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic [7:0]        mem_dout_out,
  input  logic [7:0]        mem_din_in,
  input  logic              mem_ack_in,
  output logic              rd_out,
  output logic [31:0]       rd_val_out,
  output logic [4:0]        rd_addr_out,
  output logic              stall_req_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          last_q, last_d;
  logic                store_q, store_d;
  logic                skip_q, skip_d;
  logic [2:0]          f3_q, f3_d;
  logic [31:0]         val_q, val_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         buf_q, buf_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [7:0]          dout_q, dout_d;

  logic                mem_op;
  logic [1:0]          last_in;
  logic                misalign_in;
  logic [1:0]          idx_nx;
  logic [31:0]         nxt_addr;
  logic [31:0]         val_sh;
  logic [31:0]         ld_ext;

  assign mem_op = load_in | store_in;

  // Last byte index: B=0, H=1, everything else (W and reserved codes) = 3.
  always_comb begin
    case (funct3_in[1:0])
      2'b00:   last_in = 2'd0;
      2'b01:   last_in = 2'd1;
      default: last_in = 2'd3;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_in = ((funct3_in[1:0] == 2'b01) & mem_addr_in[0]) |
                       (funct3_in[1] & (mem_addr_in[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  assign idx_nx   = idx_q + 2'd1;
  assign nxt_addr = addr_q + 32'(idx_nx);
  assign val_sh   = val_q >> {idx_nx, 3'b000};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    store_d = store_q;
    skip_d  = skip_q;
    f3_d    = f3_q;
    val_d   = val_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    req_d   = req_q;
    we_d    = we_q;
    a_d     = a_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          store_d = store_in;
          last_d  = last_in;
          f3_d    = funct3_in;
          val_d   = mem_val_in;
          addr_d  = mem_addr_in;
          idx_d   = 2'd0;
          buf_d   = 32'd0;
          skip_d  = misalign_in;
          if (misalign_in) begin
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = store_in;
            a_d     = mem_addr_in[ADDR_W-1:0];
            dout_d  = mem_val_in[7:0];
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (req_q && mem_ack_in) begin
          if (!store_q) buf_d[{idx_q, 3'b000} +: 8] = mem_din_in;
          if (idx_q != last_q) begin
            idx_d  = idx_nx;
            a_d    = nxt_addr[ADDR_W-1:0];
            dout_d = val_sh[7:0];
          end else begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        skip_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rdy_in low freezes every register, including an in-flight handshake.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      store_q <= 1'b0;
      skip_q  <= 1'b0;
      f3_q    <= 3'd0;
      val_q   <= 32'd0;
      addr_q  <= 32'd0;
      buf_q   <= 32'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      dout_q  <= 8'd0;
    end else if (rdy_in) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      store_q <= store_d;
      skip_q  <= skip_d;
      f3_q    <= f3_d;
      val_q   <= val_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      req_q   <= req_d;
      we_q    <= we_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
    end
  end

  assign mem_req_out  = req_q;
  assign mem_we_out   = we_q;
  assign mem_a_out    = a_q;
  assign mem_dout_out = dout_q;

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{buf_q[7]}}, buf_q[7:0]};
      3'b001:  ld_ext = {{16{buf_q[15]}}, buf_q[15:0]};
      3'b100:  ld_ext = {24'd0, buf_q[7:0]};
      3'b101:  ld_ext = {16'd0, buf_q[15:0]};
      default: ld_ext = buf_q;
    endcase
  end

  // Store wins when both load_in and store_in are high.
  always_comb begin
    stall_req_out = mem_op & (state_q != DONE) & ~misalign_in;
    rd_out        = rd_in;
    rd_val_out    = rd_val_in;
    rd_addr_out   = rd_addr_in;
    if (store_in) begin
      rd_out = 1'b0;
    end else if (load_in) begin
      if (state_q == DONE) begin
        rd_out     = rd_in & ~skip_q;
        rd_val_out = ld_ext;
      end else begin
        rd_out = 1'b0;
      end
    end
    if (!rst_in) begin
      stall_req_out = 1'b0;
      rd_out        = 1'b0;
      rd_val_out    = 32'd0;
      rd_addr_out   = 5'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte requests and load results are queued
// as stimulus is issued and popped when the DUT handshakes or completes.
module tb_mem_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in, rdy_in, rd_in, load_in, store_in;
  logic [31:0] rd_val_in, mem_addr_in, mem_val_in;
  logic [4:0]  rd_addr_in;
  logic [2:0]  funct3_in;
  logic        mem_req_out, mem_we_out, mem_ack_in;
  logic [31:0] mem_a_out;
  logic [7:0]  mem_dout_out, mem_din_in;
  logic        rd_out, stall_req_out;
  logic [31:0] rd_val_out;
  logic [4:0]  rd_addr_out;

  mem_stage #(.ADDR_W(32)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rd_in(rd_in),
    .rd_val_in(rd_val_in), .rd_addr_in(rd_addr_in), .load_in(load_in),
    .store_in(store_in), .funct3_in(funct3_in), .mem_addr_in(mem_addr_in),
    .mem_val_in(mem_val_in), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_a_out(mem_a_out), .mem_dout_out(mem_dout_out), .mem_din_in(mem_din_in),
    .mem_ack_in(mem_ack_in), .rd_out(rd_out), .rd_val_out(rd_val_out),
    .rd_addr_out(rd_addr_out), .stall_req_out(stall_req_out)
  );

  typedef struct { logic [31:0] a; logic we; logic [7:0] d; } req_t;
  typedef struct { logic [31:0] v; logic [4:0] ra; } wb_t;

  req_t       req_q[$];
  wb_t        wb_q[$];
  logic [7:0] mem [0:65535];
  int         n_checks = 0, n_pass = 0, ack_delay = 0, wait_cnt = 0;

  // Memory responder and request scoreboard; handshake is decided from the
  // values held between the falling edge and the next rising edge.
  task automatic tick();
    bit   hs;
    req_t e;
    @(negedge clk);
    if (!mem_req_out || !rst_in) begin
      mem_ack_in = 1'b0;
      wait_cnt   = 0;
    end else if (!mem_ack_in) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack_in = 1'b1;
        mem_din_in = mem[mem_a_out[15:0]];
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end
    hs = mem_req_out && mem_ack_in && rdy_in && rst_in;
    if (hs) begin
      n_checks++;
      if (req_q.size() == 0) begin
        $display("FAIL req_unexpected: got a=%h we=%b, expected no request", mem_a_out, mem_we_out);
      end else begin
        e = req_q.pop_front();
        if (mem_a_out !== e.a || mem_we_out !== e.we || (e.we && mem_dout_out !== e.d))
          $display("FAIL req_fields: got a=%h we=%b d=%h, expected a=%h we=%b d=%h",
                   mem_a_out, mem_we_out, mem_dout_out, e.a, e.we, e.d);
        else n_pass++;
      end
      if (mem_we_out) mem[mem_a_out[15:0]] = mem_dout_out;
    end
    @(posedge clk);
    #2;
    if (hs) mem_ack_in = 1'b0;
  endtask

  task automatic start_mem(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] val,
                           input logic [4:0] ra, input logic [31:0] exp_v,
                           input logic exp_stall);
    int   n;
    req_t r;
    wb_t  w;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      r.a  = addr + 32'(i);
      r.we = st;
      r.d  = 8'(val >> (8 * i));
      req_q.push_back(r);
    end
    if (ld && !st) begin
      w.v = exp_v; w.ra = ra;
      wb_q.push_back(w);
    end
    load_in = ld; store_in = st; funct3_in = f3; mem_addr_in = addr;
    mem_val_in = val; rd_in = 1'b1; rd_addr_in = ra; rd_val_in = 32'h0BAD_0000 ^ addr;
    #1;
    n_checks++;
    if (stall_req_out !== exp_stall)
      $display("FAIL stall_on_issue: got %b expected %b", stall_req_out, exp_stall);
    else n_pass++;
  endtask

  task automatic finish_mem(input logic [31:0] base, input int hold_at, input int hold_cycles);
    bit          done = 0, held = 0;
    logic [31:0] a0;
    logic [7:0]  d0;
    wb_t         w;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      tick();
      if (!stall_req_out) begin
        done = 1;
      end else begin
        n_checks++;
        if (rd_out !== 1'b0) $display("FAIL rd_during_stall: got %b expected 0", rd_out);
        else n_pass++;
        if (!held && hold_at >= 0 && mem_req_out && mem_a_out == base + 32'(hold_at)) begin
          held = 1; rdy_in = 1'b0; a0 = mem_a_out; d0 = mem_dout_out;
          for (int h = 0; h < hold_cycles; h++) begin
            tick();
            n_checks++;
            if (mem_req_out !== 1'b1 || mem_a_out !== a0 || mem_dout_out !== d0)
              $display("FAIL hold_frozen: got req=%b a=%h d=%h expected req=1 a=%h d=%h",
                       mem_req_out, mem_a_out, mem_dout_out, a0, d0);
            else n_pass++;
          end
          rdy_in = 1'b1;
        end
      end
    end
    n_checks++;
    if (!done) begin
      $display("FAIL access_timeout: got stall=%b expected 0 within budget", stall_req_out);
    end else begin
      n_pass++;
      n_checks++;
      if (load_in && !store_in) begin
        w = wb_q.pop_front();
        if (rd_out !== 1'b1 || rd_val_out !== w.v || rd_addr_out !== w.ra)
          $display("FAIL load_wb: got rd=%b val=%h ra=%0d expected rd=1 val=%h ra=%0d",
                   rd_out, rd_val_out, rd_addr_out, w.v, w.ra);
        else n_pass++;
      end else begin
        if (rd_out !== 1'b0) $display("FAIL store_wb: got rd=%b expected 0", rd_out);
        else n_pass++;
      end
    end
    n_checks++;
    if (mem_req_out !== 1'b0 || req_q.size() != 0)
      $display("FAIL done_idle_port: got req=%b pending=%0d expected req=0 pending=0",
               mem_req_out, req_q.size());
    else n_pass++;
    req_q.delete();
    load_in = 1'b0; store_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; load_in = 1'b1; store_in = 1'b0; rd_in = 1'b1;
    rd_val_in = 32'hFFFF_FFFF; rd_addr_in = 5'h1F; funct3_in = 3'b010;
    mem_addr_in = 32'h40; mem_val_in = 32'h0; mem_ack_in = 1'b0; mem_din_in = 8'h0;
    tick(); tick();
    n_checks++;
    if ({mem_req_out, mem_we_out, mem_a_out, mem_dout_out} !== '0)
      $display("FAIL reset_port: got req=%b we=%b a=%h d=%h expected all 0",
               mem_req_out, mem_we_out, mem_a_out, mem_dout_out);
    else n_pass++;
    n_checks++;
    if ({stall_req_out, rd_out, rd_val_out, rd_addr_out} !== '0)
      $display("FAIL reset_comb: got stall=%b rd=%b val=%h ra=%0d expected all 0",
               stall_req_out, rd_out, rd_val_out, rd_addr_out);
    else n_pass++;
    load_in = 1'b0; rst_in = 1'b1;
    tick();
  endtask

  task automatic test_passthru();
    rd_in = 1'b1; rd_val_in = 32'h1234_5678; rd_addr_in = 5'd9;
    #1;
    n_checks++;
    if (rd_out !== 1'b1 || rd_val_out !== 32'h1234_5678 || rd_addr_out !== 5'd9 || stall_req_out !== 1'b0)
      $display("FAIL passthru: got rd=%b val=%h ra=%0d stall=%b expected 1 12345678 9 0",
               rd_out, rd_val_out, rd_addr_out, stall_req_out);
    else n_pass++;
    rd_in = 1'b0;
    #1;
    n_checks++;
    if (rd_out !== 1'b0) $display("FAIL passthru_rd0: got %b expected 0", rd_out);
    else n_pass++;
    tick();
  endtask

  task automatic test_loads();
    ack_delay = 2;
    start_mem(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 5'd3, 32'hFFFF_FF80, 1'b1);
    finish_mem(32'h100, -1, 0);
    tick();
    ack_delay = 0;
    start_mem(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 5'd5, 32'h0000_F234, 1'b1);
    finish_mem(32'h200, -1, 0);
    tick();
    ack_delay = 1;
    start_mem(1'b1, 1'b0, 3'b001, 32'h200, 32'h0, 5'd6, 32'hFFFF_F234, 1'b1);
    finish_mem(32'h200, -1, 0);
    tick();
    start_mem(1'b1, 1'b0, 3'b100, 32'h100, 32'h0, 5'd7, 32'h0000_0080, 1'b1);
    finish_mem(32'h100, -1, 0);
    tick();
  endtask

  task automatic test_stores();
    ack_delay = 0;
    start_mem(1'b0, 1'b1, 3'b010, 32'h1000, 32'hDEAD_BEEF, 5'd7, 32'h0, 1'b1);
    finish_mem(32'h1000, -1, 0);
    n_checks++;
    if ({mem[16'h1003], mem[16'h1002], mem[16'h1001], mem[16'h1000]} !== 32'hDEAD_BEEF)
      $display("FAIL sw_memory: got %h expected deadbeef",
               {mem[16'h1003], mem[16'h1002], mem[16'h1001], mem[16'h1000]});
    else n_pass++;
    tick();
    ack_delay = 1;
    start_mem(1'b0, 1'b1, 3'b001, 32'h300, 32'h5555_ABCD, 5'd8, 32'h0, 1'b1);
    finish_mem(32'h300, -1, 0);
    tick();
  endtask

  task automatic test_back_to_back();
    ack_delay = 0;
    start_mem(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd10, 32'h1122_3344, 1'b1);
    finish_mem(32'h0, -1, 0);
    start_mem(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 5'd11, 32'hA5B6_C7D8, 1'b0);
    tick();
    n_checks++;
    if (mem_req_out !== 1'b0 || stall_req_out !== 1'b1)
      $display("FAIL b2b_idle: got req=%b stall=%b expected req=0 stall=1", mem_req_out, stall_req_out);
    else n_pass++;
    tick();
    n_checks++;
    if (mem_req_out !== 1'b1 || mem_a_out !== 32'h4)
      $display("FAIL b2b_start: got req=%b a=%h expected req=1 a=00000004", mem_req_out, mem_a_out);
    else n_pass++;
    finish_mem(32'h4, -1, 0);
    tick();
  endtask

  task automatic test_rdy_hold();
    ack_delay = 0;
    start_mem(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd12, 32'h1122_3344, 1'b1);
    finish_mem(32'h0, 1, 3);
    tick();
  endtask

  task automatic test_misalign();
    ack_delay = 0;
`ifdef MEM_MISALIGN_CHECK_EN
    load_in = 1'b1; store_in = 1'b0; funct3_in = 3'b010; mem_addr_in = 32'h2;
    rd_in = 1'b1; rd_addr_in = 5'd13;
    #1;
    n_checks++;
    if (stall_req_out !== 1'b0) $display("FAIL mis_stall: got %b expected 0", stall_req_out);
    else n_pass++;
    tick();
    n_checks++;
    if (mem_req_out !== 1'b0 || rd_out !== 1'b0 || stall_req_out !== 1'b0)
      $display("FAIL mis_done: got req=%b rd=%b stall=%b expected 0 0 0", mem_req_out, rd_out, stall_req_out);
    else n_pass++;
    load_in = 1'b0;
    tick();
    n_checks++;
    if (mem_req_out !== 1'b0) $display("FAIL mis_after: got req=%b expected 0", mem_req_out);
    else n_pass++;
`else
    start_mem(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 5'd13, 32'hC7D8_1122, 1'b1);
    finish_mem(32'h2, -1, 0);
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    ack_delay = 0;
    start_mem(1'b0, 1'b1, 3'b010, 32'h1000, 32'h0102_0304, 5'd14, 32'h0, 1'b1);
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (mem_req_out && mem_a_out == 32'h1002) seen = 1;
    end
    n_checks++;
    if (!seen) $display("FAIL rstmid_reach: got a=%h expected 00001002 within budget", mem_a_out);
    else n_pass++;
    rst_in = 1'b0; store_in = 1'b0;
    tick();
    n_checks++;
    if (mem_req_out !== 1'b0 || req_q.size() != 2)
      $display("FAIL rstmid_abort: got req=%b pending=%0d expected req=0 pending=2", mem_req_out, req_q.size());
    else n_pass++;
    req_q.delete();
    rst_in = 1'b1;
    tick();
    n_checks++;
    if (mem_req_out !== 1'b0 || stall_req_out !== 1'b0)
      $display("FAIL rstmid_idle: got req=%b stall=%b expected 0 0", mem_req_out, stall_req_out);
    else n_pass++;
    ack_delay = 1;
    start_mem(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 5'd15, 32'hFFFF_FF80, 1'b1);
    finish_mem(32'h100, -1, 0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h100] = 8'h80;
    mem[16'h200] = 8'h34; mem[16'h201] = 8'hF2;
    mem[0] = 8'h44; mem[1] = 8'h33; mem[2] = 8'h22; mem[3] = 8'h11;
    mem[4] = 8'hD8; mem[5] = 8'hC7; mem[6] = 8'hB6; mem[7] = 8'hA5;
    test_reset();
    test_passthru();
    test_loads();
    test_stores();
    test_back_to_back();
    test_rdy_hold();
    test_misalign();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
